// File: rtl/wb_host_pkg.sv
// rtl/wb_host_pkg.sv - shared types and constants for the Wishbone host master
package wb_host_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

    // A timeout of 0 still needs a one-bit counter so the register exists.
    function automatic int cnt_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_host_master.sv
// rtl/wb_host_master.sv - single-outstanding command/response to Wishbone classic master
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy
);

    localparam int            CW       = cnt_width(TIMEOUT_CYCLES);
    localparam int            LAST     = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LAST);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic          TO_EN    = (TIMEOUT_CYCLES != 0);

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (wbm_ack_i) begin
                    rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    rsp_dat_d = ERR_DATA;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign wbm_cyc_o = (state_q == ST_BUS);
    assign wbm_stb_o = (state_q == ST_BUS);
    assign wbm_we_o  = (state_q == ST_BUS) && we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;

endmodule

// File: tb/tb_wb_host_master.sv
// tb/tb_wb_host_master.sv - randomized transaction-level check of wb_host_master
module tb_wb_host_master;

    localparam int          T    = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i = 1'b0;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i = '0;
    logic [3:0]  wbm_sel_o;
    logic        busy;

    wb_host_master #(.TIMEOUT_CYCLES(T), .ERR_DATA(ERRD)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Transaction model: accept cycle, bus length, response wait, latched fields.
    int          m_acc = -1000;
    int          m_nbus = 0;
    int          m_w = 0;
    logic        m_we = 1'b0, m_err = 1'b0;
    logic [31:0] m_adr = '0, m_dat = '0, m_rsp = '0;
    logic [3:0]  m_sel = '0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc_cnt);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc_cnt);
    endtask

    always @(negedge clk) begin : cmp_blk
        int   r;
        logic in_bus, in_resp;
        r       = cyc_cnt - m_acc;
        in_bus  = (r >= 0) && (r < m_nbus);
        in_resp = (r >= m_nbus) && (r <= m_nbus + m_w);
        chk1("cyc", wbm_cyc_o, in_bus);
        chk1("stb", wbm_stb_o, in_bus);
        chk1("we", wbm_we_o, in_bus && m_we);
        chk32("adr", wbm_adr_o, m_adr);
        chk32("wdat", wbm_dat_o, m_dat);
        chk32("sel", {28'h0, wbm_sel_o}, {28'h0, m_sel});
        chk1("rsp_valid", rsp_valid, in_resp);
        chk1("busy", busy, in_bus || in_resp);
        chk1("cmd_ready", cmd_ready, !(in_bus || in_resp));
        if (in_resp) begin
            chk32("rsp_dat", rsp_dat, m_rsp);
            chk1("rsp_err", rsp_err, m_err);
        end
    end

    // Observed shape of the latest transaction, used for hand-computed expectations.
    int          cyc_len = 0, v_len = 0, first_v = 0;
    logic        prev_cyc = 1'b0, prev_v = 1'b0, mon_err = 1'b0, mon_we = 1'b0;
    logic [31:0] mon_rdat = '0, mon_adr = '0, mon_wdat = '0;
    logic [3:0]  mon_sel = '0;

    always @(negedge clk) begin
        if (wbm_cyc_o) begin
            cyc_len  = prev_cyc ? cyc_len + 1 : 1;
            mon_we   = wbm_we_o;
            mon_adr  = wbm_adr_o;
            mon_wdat = wbm_dat_o;
            mon_sel  = wbm_sel_o;
        end
        if (rsp_valid) begin
            if (!prev_v) begin
                first_v  = cyc_cnt;
                v_len    = 1;
                mon_rdat = rsp_dat;
                mon_err  = rsp_err;
            end else begin
                v_len = v_len + 1;
            end
        end
        prev_cyc = wbm_cyc_o;
        prev_v   = rsp_valid;
    end

    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int ad, input logic [31:0] rdata, input int w);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(posedge clk); #1;
        m_acc  = cyc_cnt;
        m_err  = (ad >= T);
        m_nbus = m_err ? T : ad + 1;
        m_w    = w;
        m_we   = we; m_adr = adr; m_dat = dat; m_sel = sel;
        m_rsp  = m_err ? ERRD : (we ? 32'h0 : rdata);
        for (int r = 0; r <= m_nbus + w; r++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_we    = 1'($urandom_range(0, 1));
            cmd_adr   = $urandom;
            cmd_dat   = $urandom;
            cmd_sel   = 4'($urandom);
            wbm_ack_i = (r < m_nbus) ? (r == ad) : 1'b1;
            wbm_dat_i = (r == ad) ? rdata : $urandom;
            rsp_ready = (r == m_nbus + w) ? 1'b1 : ((r < m_nbus) ? 1'($urandom_range(0, 1)) : 1'b0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0; wbm_ack_i = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            wbm_ack_i = 1'($urandom_range(0, 1));
            wbm_dat_i = $urandom;
            rsp_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        wbm_ack_i = 1'b0; rsp_ready = 1'b0;
    endtask

    task automatic reset_model;
        m_acc = -1000; m_nbus = 0; m_w = 0;
        m_we = 1'b0; m_adr = '0; m_dat = '0; m_sel = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk1("reset cmd_ready", cmd_ready, 1'b1);
        chk32("reset rsp_dat", rsp_dat, 32'h0);
        chk1("reset rsp_err", rsp_err, 1'b0);
        chk32("reset adr", wbm_adr_o, 32'h0);
        idle_gap(2);

        txn(1'b0, 32'h1000_0000, 32'h0, 4'hF, 2, 32'h1234_5678, 0);
        chk32("read cyc_len", 32'(cyc_len), 32'd3);
        chk32("read rsp_dat", mon_rdat, 32'h1234_5678);
        chk1("read rsp_err", mon_err, 1'b0);

        txn(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, 0, 32'hFFFF_FFFF, 0);
        chk32("write cyc_len", 32'(cyc_len), 32'd1);
        chk1("write we", mon_we, 1'b1);
        chk32("write adr", mon_adr, 32'h3000_0004);
        chk32("write dat", mon_wdat, 32'hA5A5_0001);
        chk32("write sel", {28'h0, mon_sel}, 32'hF);
        chk32("write rsp_dat", mon_rdat, 32'h0);
        chk32("write latency", 32'(first_v - m_acc + 1), 32'd2);

        txn(1'b0, 32'h2000_0010, 32'h0, 4'h3, 20, 32'h5555_5555, 1);
        chk32("timeout cyc_len", 32'(cyc_len), 32'd8);
        chk1("timeout rsp_err", mon_err, 1'b1);
        chk32("timeout rsp_dat", mon_rdat, 32'hDEAD_BEEF);

        txn(1'b0, 32'h2000_0020, 32'h0, 4'hC, 7, 32'hCAFE_0039, 0);
        chk32("late ack cyc_len", 32'(cyc_len), 32'd8);
        chk1("late ack rsp_err", mon_err, 1'b0);
        chk32("late ack rsp_dat", mon_rdat, 32'hCAFE_0039);

        txn(1'b0, 32'h4000_0000, 32'h0, 4'h1, 1, 32'h0BAD_F00D, 5);
        chk32("held rsp v_len", 32'(v_len), 32'd6);
        chk32("held rsp_dat", mon_rdat, 32'h0BAD_F00D);

        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h5000_0000; cmd_dat = 32'h1; cmd_sel = 4'h5;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        m_acc = cyc_cnt; m_nbus = T; m_w = 0; m_err = 1'b1; m_rsp = ERRD;
        m_we = 1'b1; m_adr = 32'h5000_0000; m_dat = 32'h1; m_sel = 4'h5;
        @(posedge clk); #3;
        rst_n = 1'b0;
        reset_model();
        #1;
        chk1("async rst cyc", wbm_cyc_o, 1'b0);
        chk1("async rst stb", wbm_stb_o, 1'b0);
        chk1("async rst busy", busy, 1'b0);
        chk1("async rst rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        chk1("post rst cmd_ready", cmd_ready, 1'b1);
        txn(1'b0, 32'h6000_0000, 32'h0, 4'hF, 0, 32'h7777_8888, 0);
        chk32("post rst rsp_dat", mon_rdat, 32'h7777_8888);
        chk32("post rst cyc_len", 32'(cyc_len), 32'd1);

        for (int i = 0; i < 80; i++) begin
            txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                $urandom_range(0, 11), $urandom, $urandom_range(0, 3));
            idle_gap($urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
